// File: rtl/clk_lock_sequencer_if.sv
// Clock-lock sequencer bundle: wizard status/controls, software gate request and
// sequencer status outputs.
//   pll_locked  : wizard locked status (asynchronous to clk_in1)
//   gate_req    : software clock-enable request (level, clk_in1 domain)
//   pll_resetn  : wizard PLL reset, active low
//   clk_gate_en : wizard output clock gate enable
//   sys_rst     : active-high reset for logic on the generated clocks
//   fault       : sticky, PLL never locked
//   state_o     : current sequencer state encoding
//   loss_cnt    : saturating lock-loss event count
// Modport master is the sequencer side; slave is the environment side.
interface clk_lock_sequencer_if;
  logic       pll_locked;
  logic       gate_req;
  logic       pll_resetn;
  logic       clk_gate_en;
  logic       sys_rst;
  logic       fault;
  logic [2:0] state_o;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_locked, gate_req,
    output pll_resetn, clk_gate_en, sys_rst, fault, state_o, loss_cnt
  );

  modport slave (
    output pll_locked, gate_req,
    input  pll_resetn, clk_gate_en, sys_rst, fault, state_o, loss_cnt
  );
endinterface

// File: rtl/clk_lock_sequencer.sv
// Clock-lock sequencer placed directly upstream of the clock wizard. Pulses the PLL
// reset, waits for lock, qualifies it, ungates the clock and then releases the
// downstream reset. Recovers from lock loss and flags a sticky fault if the PLL
// never locks.
//
// Ports:
//   clk_in1 : free-running reference clock (wizard input clock net)
//   reset   : synchronous active-high reset
//   bus     : clk_lock_sequencer_if.master (pll_locked, gate_req in;
//             pll_resetn, clk_gate_en, sys_rst, fault, state_o, loss_cnt out)
//
// Build option: define CLK_LOCK_SEQ_AUTO_RETRY_EN to build the retry logic
// (MAX_RETRY re-attempts after a lock timeout, lock loss re-enters PLL reset).
// Without it the first timeout or any lock loss goes straight to FAULT.
module clk_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1000,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned RELEASE_DLY   = 8,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input logic                  clk_in1,
  input logic                  reset,
  clk_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StGate     = 3'd3,
    StRun      = 3'd4,
    StFault    = 3'd5
  } state_e;

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 || RELEASE_DLY < 1 ||
      MAX_RETRY > 255 || CNT_W < 2 || CNT_W > 32) begin : gen_param_check
    $error("clk_lock_sequencer: illegal parameter value");
  end

  // Terminal counts: each timed state lasts exactly N cycles, counting 0..N-1.
  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ReleaseLast = CNT_W'(RELEASE_DLY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, lk_q;
  logic             pll_resetn_q, pll_resetn_d;
  logic             clk_gate_en_q, clk_gate_en_d;
  logic             sys_rst_q, sys_rst_d;
  logic             fault_q, fault_d;

`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
  localparam int unsigned RetryW = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RetryW-1:0] retry_q, retry_d;
`endif

  // Next-state logic; every decision uses the synchronized lock lk_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (lk_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = StPllRst;
          end else begin
            state_d = StFault;
          end
`else
          state_d = StFault;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStable: begin
        // Any drop restarts both the qualification and the timeout window.
        if (!lk_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StGate;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGate, StRun: begin
        // Lock loss wins over the release-delay expiry.
        if (!lk_q) begin
          cnt_d  = '0;
          loss_d = (loss_q == 8'hff) ? loss_q : loss_q + 8'd1;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
          state_d = StPllRst;
`else
          state_d = StFault;
`endif
        end else if (state_q == StGate) begin
          if (cnt_q == ReleaseLast) begin
            state_d = StRun;
            cnt_d   = '0;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
            retry_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFault: ;
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_comb begin
    pll_resetn_d  = 1'b1;
    clk_gate_en_d = 1'b0;
    sys_rst_d     = 1'b1;
    fault_d       = fault_q;
    unique case (state_d)
      StPllRst:             pll_resetn_d = 1'b0;
      StWaitLock, StStable: ;
      StGate:               clk_gate_en_d = bus.gate_req;
      StRun: begin
        clk_gate_en_d = bus.gate_req;
        sys_rst_d     = 1'b0;
      end
      StFault: begin
        pll_resetn_d = 1'b0;
        fault_d      = 1'b1;
      end
      default:              pll_resetn_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      lk_q          <= 1'b0;
      state_q       <= StPllRst;
      cnt_q         <= '0;
      loss_q        <= '0;
      pll_resetn_q  <= 1'b0;
      clk_gate_en_q <= 1'b0;
      sys_rst_q     <= 1'b1;
      fault_q       <= 1'b0;
    end else begin
      sync1_q       <= bus.pll_locked;
      lk_q          <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      loss_q        <= loss_d;
      pll_resetn_q  <= pll_resetn_d;
      clk_gate_en_q <= clk_gate_en_d;
      sys_rst_q     <= sys_rst_d;
      fault_q       <= fault_d;
    end
  end

`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign bus.pll_resetn  = pll_resetn_q;
  assign bus.clk_gate_en = clk_gate_en_q;
  assign bus.sys_rst     = sys_rst_q;
  assign bus.fault       = fault_q;
  assign bus.state_o     = state_q;
  assign bus.loss_cnt    = loss_q;

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// Self-checking bench for clk_lock_sequencer: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model of the sequencing rules.
module tb_clk_lock_sequencer;
  localparam int RST_CYCLES    = 16;
  localparam int LOCK_TIMEOUT  = 1000;
  localparam int STABLE_CYCLES = 64;
  localparam int RELEASE_DLY   = 8;
  localparam int MAX_RETRY     = 3;

  logic clk_in1 = 1'b0;
  logic reset   = 1'b1;

  clk_lock_sequencer_if bus ();

  clk_lock_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .RELEASE_DLY  (RELEASE_DLY),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16)
  ) dut (
    .clk_in1(clk_in1),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in1 = ~clk_in1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: states 0..5, m_age = cycles completed in the current state.
  int m_state, m_age, m_loss;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
  int m_retry;
`endif
  bit m_h0, m_h1, m_gate, m_valid;

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk_in1);
      cyc++;
      begin : model_step
        int  nxt;
        bit  lk;
        logic [14:0] exp_v, act_v;
        if (reset) begin
          m_state = 0; m_age = 0; m_loss = 0;
          m_h0 = 1'b0; m_h1 = 1'b0; m_gate = 1'b0; m_valid = 1'b1;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
          m_retry = 0;
`endif
        end else if (m_valid) begin
          lk = m_h1; m_h1 = m_h0; m_h0 = bus.pll_locked;
          nxt = m_state;
          m_age++;
          case (m_state)
            0: if (m_age == RST_CYCLES) nxt = 1;
            1: begin
              if (lk) nxt = 2;
              else if (m_age == LOCK_TIMEOUT) begin
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
                if (m_retry < MAX_RETRY) begin m_retry++; nxt = 0; end
                else nxt = 5;
`else
                nxt = 5;
`endif
              end
            end
            2: if (!lk) nxt = 1; else if (m_age == STABLE_CYCLES) nxt = 3;
            3, 4: begin
              if (!lk) begin
                m_loss = (m_loss < 255) ? m_loss + 1 : 255;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
                nxt = 0;
`else
                nxt = 5;
`endif
              end else if (m_state == 3 && m_age == RELEASE_DLY) begin
                nxt = 4;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
                m_retry = 0;
`endif
              end
            end
            default: ;
          endcase
          if (nxt != m_state) m_age = 0;
          m_state = nxt;
          m_gate  = (nxt == 3 || nxt == 4) ? bus.gate_req : 1'b0;
        end
        #1;
        if (m_valid) begin
          exp_v = {3'(m_state), (m_state >= 1 && m_state <= 4), m_gate, (m_state != 4),
                   (m_state == 5), 8'(m_loss)};
          act_v = {bus.state_o, bus.pll_resetn, bus.clk_gate_en, bus.sys_rst, bus.fault,
                   bus.loss_cnt};
          check("model {state,resetn,gate,sys_rst,fault,loss}", act_v, exp_v);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in1);
  endtask

  // Counts negedges (from the current one) while pll_resetn holds the given level.
  task automatic run_len(input logic val, output int n);
    n = 0;
    while (bus.pll_resetn === val && n < 5000) begin
      n++;
      @(negedge clk_in1);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, output bit ok);
    int n = 0;
    while (bus.state_o !== s && n < bound) begin
      @(negedge clk_in1);
      n++;
    end
    ok = (bus.state_o === s);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"},       bus.state_o, 0);
    check({tag, " pll_resetn"},  bus.pll_resetn, 0);
    check({tag, " clk_gate_en"}, bus.clk_gate_en, 0);
    check({tag, " sys_rst"},     bus.sys_rst, 1);
    check({tag, " fault"},       bus.fault, 0);
    check({tag, " loss_cnt"},    bus.loss_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_r, t_g, t_s, to_cnt, exp_pulses;
    bit ok, bad;
    bus.pll_locked = 1'b0;
    bus.gate_req   = 1'b1;
    reset          = 1'b1;

    // Reset values and nominal lock.
    tick(3);
    check_reset_values("reset");
    reset = 1'b0;
    run_len(1'b0, n);
    check("nominal pll_resetn low cycles", n, RST_CYCLES);
    t_r = cyc;
    tick(100);
    bus.pll_locked = 1'b1;
    n = 0;
    while (bus.clk_gate_en !== 1'b1 && n < 400) begin tick(1); n++; end
    t_g = cyc;
    check("nominal clk_gate_en rise after pll_resetn", t_g - t_r, 167);
    n = 0;
    while (bus.sys_rst !== 1'b0 && n < 50) begin tick(1); n++; end
    t_s = cyc;
    check("nominal sys_rst release after gate", t_s - t_g, RELEASE_DLY);
    check("nominal state RUN", bus.state_o, 4);

    // Gate control in RUN.
    bus.gate_req = 1'b0;
    tick(1);
    check("gate_req=0 clk_gate_en", bus.clk_gate_en, 0);
    check("gate_req=0 sys_rst", bus.sys_rst, 0);
    check("gate_req=0 state", bus.state_o, 4);
    bus.gate_req = 1'b1;
    tick(1);
    check("gate_req=1 clk_gate_en", bus.clk_gate_en, 1);
    check("gate_req=1 state", bus.state_o, 4);

    // Lock loss in RUN: reaction three edges after the drop is sampled.
    bus.pll_locked = 1'b0;
    tick(2);
    check("loss +2 clk_gate_en still high", bus.clk_gate_en, 1);
    tick(1);
    check("loss +3 clk_gate_en", bus.clk_gate_en, 0);
    check("loss +3 sys_rst", bus.sys_rst, 1);
    check("loss +3 loss_cnt", bus.loss_cnt, 1);
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
    check("loss +3 state PLL_RST", bus.state_o, 0);
    bus.pll_locked = 1'b1;
    run_len(1'b0, n);
    check("loss new pll_resetn pulse", n, RST_CYCLES);
`else
    check("loss +3 state FAULT", bus.state_o, 5);
    check("loss +3 fault", bus.fault, 1);
`endif

    // Glitch during qualification.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    bus.pll_locked = 1'b1;
    wait_state(3'd2, 100, ok);
    check("glitch reached STABLE", ok, 1);
    tick(30);
    bus.pll_locked = 1'b0;
    tick(5);
    bus.pll_locked = 1'b1;
    check("glitch back to WAIT_LOCK", bus.state_o, 1);
    wait_state(3'd2, 50, ok);
    check("glitch re-entered STABLE", ok, 1);
    t_r = cyc;
    bad = 1'b0;
    n = 0;
    while (bus.state_o !== 3'd3 && n < 200) begin
      if (bus.clk_gate_en !== 1'b0) bad = 1'b1;
      tick(1);
      n++;
    end
    check("glitch clk_gate_en held low", bad, 0);
    check("glitch full requalification", cyc - t_r, STABLE_CYCLES);

    // Reset mid-qualification.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wait_state(3'd2, 100, ok);
    check("midreset reached STABLE", ok, 1);
    tick(40);
    reset = 1'b1;
    tick(1);
    check_reset_values("midreset");
    reset = 1'b0;
    run_len(1'b0, n);
    check("midreset pll_resetn restart", n, RST_CYCLES);

    // Lock never arrives.
    reset = 1'b1;
    bus.pll_locked = 1'b0;
    tick(2);
    reset = 1'b0;
`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
    exp_pulses = MAX_RETRY + 1;
`else
    exp_pulses = 1;
`endif
    for (int i = 0; i < exp_pulses; i++) begin
      run_len(1'b0, n);
      check($sformatf("timeout pulse %0d low", i), n, RST_CYCLES);
      run_len(1'b1, n);
      check($sformatf("timeout wait %0d high", i), n, LOCK_TIMEOUT);
    end
    check("timeout fault", bus.fault, 1);
    check("timeout state FAULT", bus.state_o, 5);
    bus.pll_locked = 1'b1;
    tick(20);
    check("fault is terminal", bus.state_o, 5);

`ifdef CLK_LOCK_SEQ_AUTO_RETRY_EN
    // Lock-loss counter saturation.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    to_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      wait_state(3'd4, 300, ok);
      if (!ok) to_cnt++;
      bus.pll_locked = 1'b0;
      tick(1);
      bus.pll_locked = 1'b1;
      tick(4);
    end
    wait_state(3'd4, 300, ok);
    check("saturation loop reached RUN", to_cnt, 0);
    check("loss_cnt saturated", bus.loss_cnt, 255);
`endif

    // Randomized phase.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int b = 0; b < 60; b++) begin
      int len;
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
      bus.pll_locked = $urandom_range(0, 2) != 0;
      len = bus.pll_locked ? $urandom_range(20, 250) : $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 15) == 0) bus.gate_req = ~bus.gate_req;
        tick(1);
      end
    end
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_lock_sequencer.md
Name: clk_lock_sequencer

Overview:
- Control stage directly upstream of the clock wizard.
- Drives the wizard's active-low PLL reset (`resetn`) and its `clk_gate_en`, and consumes its `locked` status.
- Sequences PLL reset → lock wait → lock qualification → clock ungating → downstream reset release.
- Recovers automatically from lock loss and flags a fault if the PLL never locks.

Parameters:
- RST_CYCLES, 16: cycles `pll_resetn` is held low per PLL reset attempt (≥1).
- LOCK_TIMEOUT, 1000: cycles allowed in WAIT_LOCK before the attempt is declared failed (≥2).
- STABLE_CYCLES, 64: consecutive synchronized-locked cycles required before ungating (≥1).
- RELEASE_DLY, 8: cycles between `clk_gate_en` assertion and `sys_rst` deassertion (≥1).
- MAX_RETRY, 3: PLL reset re-attempts after the first failed attempt (≥0).
- CNT_W, 16: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_DLY).

Ports:
- clk_in1, input, 1: free-running reference clock (same net as the wizard input clock).
- reset, input, 1: synchronous, active-high reset.
- pll_locked, input, 1: wizard `locked`; asynchronous, synchronized internally.
- gate_req, input, 1: software clock-enable request; level, synchronous to clk_in1.
- pll_resetn, output, 1: to wizard `resetn`; active low.
- clk_gate_en, output, 1: to wizard `clk_gate_en`.
- sys_rst, output, 1: active-high reset for logic on the generated clocks.
- fault, output, 1: sticky; the PLL failed to lock after all retries.
- state_o, output, 3: current FSM state encoding.
- loss_cnt, output, 8: saturating count of lock-loss events seen in GATE or RUN.

Behaviour:
- All flops update on the rising edge of clk_in1; `reset` is sampled synchronously.
- Reset values:
  - state = PLL_RST, counter = 0, retry = 0.
  - pll_resetn = 0, clk_gate_en = 0, sys_rst = 1, fault = 0, loss_cnt = 0.
  - Synchronizer flops cleared to 0.
- Lock synchronizer: `pll_locked` passes through a 2-flop synchronizer to give `lk`; adds 2 cycles of latency. All FSM decisions use `lk`.
- State encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, GATE=3, RUN=4, FAULT=5. All outputs are registered.
- PLL_RST:
  - pll_resetn=0, clk_gate_en=0, sys_rst=1.
  - Counter increments each cycle.
  - After exactly RST_CYCLES cycles in this state: go to WAIT_LOCK, counter cleared, pll_resetn=1 on the following cycle.
- WAIT_LOCK:
  - If lk=1: go to STABLE, counter cleared.
  - Otherwise the counter increments. On the cycle it reaches LOCK_TIMEOUT-1 with lk=0, the attempt fails:
    - if retry < MAX_RETRY: retry+1, go to PLL_RST;
    - else: go to FAULT.
- STABLE:
  - If lk=0: go to WAIT_LOCK, counter cleared. The timeout window restarts; retry is unchanged.
  - After STABLE_CYCLES consecutive cycles with lk=1: go to GATE, counter cleared.
- GATE:
  - clk_gate_en = gate_req (registered, 1-cycle latency); sys_rst held at 1.
  - After RELEASE_DLY cycles: go to RUN, sys_rst=0, retry cleared.
- RUN:
  - sys_rst=0; clk_gate_en follows gate_req with 1-cycle latency.
  - gate_req toggling never affects sys_rst or state.
- Lock loss (lk=0 while in GATE or RUN):
  - Next cycle: clk_gate_en=0, sys_rst=1, state=PLL_RST, counter cleared.
  - loss_cnt increments, saturating at 255; retry is not changed.
  - Lock loss has priority over the RELEASE_DLY expiry in the same cycle.
- FAULT:
  - pll_resetn=0, clk_gate_en=0, sys_rst=1, fault=1.
  - Terminal state; exited only by `reset`.
- `reset` asserted in any state, mid-count included, restores all reset values on the next edge.
- loss_cnt and fault are cleared only by `reset`.

Optional Feature:
- Macro: CLK_LOCK_SEQ_AUTO_RETRY_EN.
- Defined: lock-timeout retries per MAX_RETRY as described above. Lock loss in GATE or RUN re-enters PLL_RST.
- Undefined: retry logic is not built. The first WAIT_LOCK timeout goes to FAULT. Lock loss in GATE or RUN goes to FAULT (after incrementing loss_cnt) instead of PLL_RST. MAX_RETRY is ignored.

Test Plan:
- Nominal lock: reset released, pll_locked rises 100 cycles after pll_resetn rises, gate_req=1 → pll_resetn low exactly 16 cycles; clk_gate_en=1 at 100+2+64+1 cycles after pll_resetn rises; sys_rst=0 8 cycles after clk_gate_en rises; state_o=4.
- Glitch in STABLE: pll_locked drops for 5 cycles after 30 locked cycles → state returns to WAIT_LOCK; the full 64-cycle qualification restarts; clk_gate_en stays 0 until it completes.
- Timeout and retry: pll_locked held 0 → four PLL_RST pulses of 16 cycles spaced by 1000-cycle waits, then fault=1 and state_o=5. With the macro undefined: one pulse, then fault.
- Lock loss in RUN: pll_locked drops → clk_gate_en=0 and sys_rst=1 three cycles later; loss_cnt=1; new 16-cycle pll_resetn pulse. Repeated 300 times, loss_cnt saturates at 255.
- Gate control: in RUN, toggle gate_req 1→0→1 → clk_gate_en follows with 1-cycle latency; sys_rst stays 0; state_o stays 4.
- Reset mid-operation: assert reset in STABLE at counter=40 → next cycle all outputs at reset values; the sequence restarts from PLL_RST.
